// File: rtl/sobel_pkg.sv
// Shared definitions for the sobel raster-scan controller: image size defaults,
// scan FSM states and the 3x3 window packing layout.
package sobel_pkg;

  // Default frame geometry (VGA).
  localparam int unsigned MaxRowDefault = 480;
  localparam int unsigned MaxColDefault = 640;

  // Width of every row/column coordinate carried on the ports.
  localparam int unsigned CoordW = 10;

  // Bit offsets of each neighbour inside the 64-bit window word.
  localparam int unsigned WinTlOff = 56;
  localparam int unsigned WinTOff  = 48;
  localparam int unsigned WinTrOff = 40;
  localparam int unsigned WinMlOff = 32;
  localparam int unsigned WinMrOff = 24;
  localparam int unsigned WinBlOff = 16;
  localparam int unsigned WinBOff  = 8;
  localparam int unsigned WinBrOff = 0;

  typedef enum logic [2:0] {
    StIdle,
    StFill,
    StRun,
    StWaitSob,
    StEmit,
    StFlush
  } scan_state_e;

  // Packs the eight neighbours of a centre pixel; the centre itself is not sent.
  function automatic logic [63:0] pack_window(
    input logic [7:0] tl, input logic [7:0] t,  input logic [7:0] tr,
    input logic [7:0] ml, input logic [7:0] mr,
    input logic [7:0] bl, input logic [7:0] b,  input logic [7:0] br
  );
    logic [63:0] w;
    w = '0;
    w[WinTlOff +: 8] = tl;
    w[WinTOff  +: 8] = t;
    w[WinTrOff +: 8] = tr;
    w[WinMlOff +: 8] = ml;
    w[WinMrOff +: 8] = mr;
    w[WinBlOff +: 8] = bl;
    w[WinBOff  +: 8] = b;
    w[WinBrOff +: 8] = br;
    return w;
  endfunction

endpackage

// File: rtl/sobel_scan_ctrl_if.sv
// Pixel-in stream, sobel engine handshake and filtered-pixel-out stream.
// master = the scan controller, slave = its environment (source, engine, sink).
interface sobel_scan_ctrl_if;
  import sobel_pkg::*;

  logic [7:0]        pix_in;
  logic              pix_valid;
  logic              pix_ready;

  logic [63:0]       win_pixels;
  logic [CoordW-1:0] win_row;
  logic [CoordW-1:0] win_col;
  logic              sob_start;
  logic              sob_done;
  logic [7:0]        sob_pixel;

  logic [7:0]        out_pixel;
  logic              out_valid;
  logic              out_ready;

  modport master (
    input  pix_in, pix_valid,
    output pix_ready,
    output win_pixels, win_row, win_col, sob_start,
    input  sob_done, sob_pixel,
    output out_pixel, out_valid,
    input  out_ready
  );

  modport slave (
    output pix_in, pix_valid,
    input  pix_ready,
    input  win_pixels, win_row, win_col, sob_start,
    output sob_done, sob_pixel,
    input  out_pixel, out_valid,
    output out_ready
  );

endinterface

// File: rtl/sobel_line_buffer.sv
// One image line of 8-bit pixels. Read is combinational so the old value at an
// address can be forwarded in the same cycle that address is overwritten.
module sobel_line_buffer #(
  parameter int unsigned Depth = 640,
  parameter int unsigned AddrW = 10
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AddrW-1:0] addr,
  input  logic [7:0]       wdata,
  output logic [7:0]       rdata
);

  logic [7:0] mem [Depth];

  assign rdata = mem[addr];

  // Write the new pixel for this column; contents are never cleared.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/sobel_scan_ctrl.sv
// Raster-scan sequencer in front of the sobel engine. Buffers two lines, builds
// 3x3 windows, sends interior windows to the engine and streams results out in
// raster order with borders forced to 0.
// Optional: define SOBEL_SCAN_STATS_EN to add the edge_count output.
module sobel_scan_ctrl
  import sobel_pkg::*;
#(
  parameter int unsigned MAX_ROW = MaxRowDefault,
  parameter int unsigned MAX_COL = MaxColDefault
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  sobel_scan_ctrl_if.master   bus,
  output logic                busy,
  output logic                frame_done
`ifdef SOBEL_SCAN_STATS_EN
  ,
  output logic [18:0]         edge_count
`endif
);

  localparam int unsigned AddrW = (MAX_COL > 1) ? $clog2(MAX_COL) : 1;
  localparam logic [CoordW-1:0] LastRow = CoordW'(MAX_ROW - 1);
  localparam logic [CoordW-1:0] LastCol = CoordW'(MAX_COL - 1);
  localparam logic [CoordW-1:0] PenRow  = CoordW'(MAX_ROW - 2);
  localparam logic [CoordW-1:0] PenCol  = CoordW'(MAX_COL - 2);
  localparam logic [CoordW-1:0] OneRow  = CoordW'(1);

  scan_state_e state_q, state_d;

  logic [CoordW-1:0] ri_q, ci_q;  // position of the next input pixel
  logic [CoordW-1:0] ro_q, co_q;  // position of the next output pixel
  logic [7:0]        win_q [3][3];  // [row top..bot][col left..right]
  logic [CoordW-1:0] win_row_q, win_col_q;
  logic [7:0]        out_pix_q;
  logic              sob_start_q;
  logic              frame_done_q;

  logic       pix_ready, out_valid;
  logic       pix_acc, out_acc;
  logic       frame_start, issue, emit_border, take_sob, to_flush, done_d;
  logic       at_border, out_is_pen, out_is_last, fill_last;
  logic [7:0] lb0_rd, lb1_rd;

  assign pix_acc = bus.pix_valid & pix_ready;
  assign out_acc = out_valid & bus.out_ready;

  assign at_border   = (ro_q == '0) || (ro_q == LastRow) || (co_q == '0) || (co_q == LastCol);
  // Last output produced in RUN is the final interior centre; the rest are flushed.
  assign out_is_pen  = (ro_q == PenRow) && (co_q == PenCol);
  assign out_is_last = (ro_q == LastRow) && (co_q == LastCol);
  // Pixel (1,0) completes the MAX_COL+1 pixel lead before the first output.
  assign fill_last   = (ri_q == OneRow) && (ci_q == '0);

  // lb0 holds row ri-1, lb1 holds row ri-2; lb0's old value cascades into lb1.
  sobel_line_buffer #(
    .Depth (MAX_COL),
    .AddrW (AddrW)
  ) u_lb0 (
    .clk   (clk),
    .we    (pix_acc),
    .addr  (ci_q[AddrW-1:0]),
    .wdata (bus.pix_in),
    .rdata (lb0_rd)
  );

  sobel_line_buffer #(
    .Depth (MAX_COL),
    .AddrW (AddrW)
  ) u_lb1 (
    .clk   (clk),
    .we    (pix_acc),
    .addr  (ci_q[AddrW-1:0]),
    .wdata (lb0_rd),
    .rdata (lb1_rd)
  );

  // Scan FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Scan FSM next state and handshake controls.
  always_comb begin
    state_d     = state_q;
    pix_ready   = 1'b0;
    out_valid   = 1'b0;
    frame_start = 1'b0;
    issue       = 1'b0;
    emit_border = 1'b0;
    take_sob    = 1'b0;
    to_flush    = 1'b0;
    done_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          frame_start = 1'b1;
          state_d     = StFill;
        end
      end
      StFill: begin
        pix_ready = 1'b1;
        if (bus.pix_valid && fill_last) begin
          state_d = StRun;
        end
      end
      StRun: begin
        pix_ready = 1'b1;
        if (bus.pix_valid) begin
          if (at_border) begin
            emit_border = 1'b1;
            state_d     = StEmit;
          end else begin
            issue   = 1'b1;
            state_d = StWaitSob;
          end
        end
      end
      StWaitSob: begin
        if (bus.sob_done) begin
          take_sob = 1'b1;
          state_d  = StEmit;
        end
      end
      StEmit: begin
        out_valid = 1'b1;
        if (bus.out_ready) begin
          if (out_is_pen) begin
            to_flush = 1'b1;
            state_d  = StFlush;
          end else begin
            state_d = StRun;
          end
        end
      end
      StFlush: begin
        out_valid = 1'b1;
        if (bus.out_ready && out_is_last) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Input and output raster counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ri_q <= '0;
      ci_q <= '0;
      ro_q <= '0;
      co_q <= '0;
    end else if (frame_start) begin
      ri_q <= '0;
      ci_q <= '0;
      ro_q <= '0;
      co_q <= '0;
    end else begin
      if (pix_acc) begin
        if (ci_q == LastCol) begin
          ci_q <= '0;
          ri_q <= ri_q + 1'b1;
        end else begin
          ci_q <= ci_q + 1'b1;
        end
      end
      if (out_acc) begin
        if (co_q == LastCol) begin
          co_q <= '0;
          ro_q <= ro_q + 1'b1;
        end else begin
          co_q <= co_q + 1'b1;
        end
      end
    end
  end

  // 3x3 window: shift left on every accepted pixel, new column from buffers + input.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else if (pix_acc) begin
      for (int r = 0; r < 3; r++) begin
        win_q[r][0] <= win_q[r][1];
        win_q[r][1] <= win_q[r][2];
      end
      win_q[0][2] <= lb1_rd;
      win_q[1][2] <= lb0_rd;
      win_q[2][2] <= bus.pix_in;
    end
  end

  // Engine request coordinates, result capture and one-cycle pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win_row_q    <= '0;
      win_col_q    <= '0;
      out_pix_q    <= '0;
      sob_start_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      sob_start_q  <= issue;
      frame_done_q <= done_d;
      if (issue) begin
        win_row_q <= ro_q;
        win_col_q <= co_q;
      end
      if (emit_border || to_flush) begin
        out_pix_q <= '0;
      end else if (take_sob) begin
        out_pix_q <= bus.sob_pixel;
      end
    end
  end

`ifdef SOBEL_SCAN_STATS_EN
  logic [18:0] edge_cnt_q;

  // Count saturated (edge) pixels handed downstream in the current frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      edge_cnt_q <= '0;
    end else if (frame_start) begin
      edge_cnt_q <= '0;
    end else if (out_acc && (out_pix_q == 8'hFF)) begin
      edge_cnt_q <= edge_cnt_q + 1'b1;
    end
  end

  assign edge_count = edge_cnt_q;
`endif

  assign bus.pix_ready  = pix_ready;
  assign bus.out_valid  = out_valid;
  assign bus.out_pixel  = out_pix_q;
  assign bus.sob_start  = sob_start_q;
  assign bus.win_row    = win_row_q;
  assign bus.win_col    = win_col_q;
  assign bus.win_pixels = pack_window(win_q[0][0], win_q[0][1], win_q[0][2],
                                      win_q[1][0], win_q[1][2],
                                      win_q[2][0], win_q[2][1], win_q[2][2]);
  assign busy           = (state_q != StIdle);
  assign frame_done     = frame_done_q;

endmodule

// File: tb/tb_sobel_scan_ctrl.sv
// Directed bench for sobel_scan_ctrl on a 5x6 frame with a latency-programmable
// engine responder and a stallable output sink.
module tb_sobel_scan_ctrl;
  import sobel_pkg::*;

  localparam int R = 5;
  localparam int C = 6;
  localparam int N = R * C;
  localparam int NInt = (R - 2) * (C - 2);

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic busy, frame_done;
`ifdef SOBEL_SCAN_STATS_EN
  logic [18:0] edge_count;
`endif

  sobel_scan_ctrl_if bus ();

  sobel_scan_ctrl #(
    .MAX_ROW (R),
    .MAX_COL (C)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .bus        (bus),
    .busy       (busy),
    .frame_done (frame_done)
`ifdef SOBEL_SCAN_STATS_EN
    ,
    .edge_count (edge_count)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Engine responder: returns eng_val eng_lat cycles after each sob_start.
  int         eng_lat = 3;
  logic [7:0] eng_val = 8'h00;
  int         eng_cnt = 0;
  int         sob_starts = 0;
  int         last_start_cyc = 0;
  int         wait_viol = 0;
  int         cap_row = 0;
  int         cap_col = 0;
  int         cap_hits = 0;
  logic [63:0] cap_win = '0;

  initial begin
    bus.sob_done  = 1'b0;
    bus.sob_pixel = 8'h00;
    forever begin
      @(negedge clk);
      bus.sob_done = 1'b0;
      if (!reset) begin
        eng_cnt = 0;
      end else begin
        if (eng_cnt > 0) begin
          if (bus.pix_ready !== 1'b0) wait_viol++;
          eng_cnt--;
          if (eng_cnt == 0) begin
            bus.sob_done  = 1'b1;
            bus.sob_pixel = eng_val;
          end
        end
        if (bus.sob_start === 1'b1) begin
          sob_starts++;
          last_start_cyc = cyc;
          eng_cnt = eng_lat;
          if (int'(bus.win_row) == cap_row && int'(bus.win_col) == cap_col) begin
            cap_hits++;
            cap_win = bus.win_pixels;
          end
        end
      end
    end
  end

  // Output sink: records accepted pixels, optionally stalls one output.
  int         out_cnt = 0;
  logic [7:0] got [256];
  int         fd_cnt = 0;
  int         fd_cyc = 0;
  int         last_hs_cyc = 0;
  int         start_checked = 0;
  int         lat_bad = 0;
  logic       prev_valid = 1'b0;
  int         stall_idx = -1;
  int         stall_len = 0;
  int         stall_cycles = 0;
  int         stall_bad = 0;
  logic [7:0] stall_pix = 8'h00;

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_valid    = 1'b0;
        bus.out_ready = 1'b1;
        start_checked = sob_starts;
      end else begin
        if (frame_done === 1'b1) begin
          fd_cnt++;
          fd_cyc = cyc;
        end
        if (bus.out_valid === 1'b1 && !prev_valid && sob_starts != start_checked) begin
          if (cyc - last_start_cyc != eng_lat + 1) lat_bad++;
          start_checked = sob_starts;
        end
        bus.out_ready = 1'b1;
        if (bus.out_valid === 1'b1 && out_cnt == stall_idx && stall_cycles < stall_len) begin
          if (stall_cycles == 0) stall_pix = bus.out_pixel;
          if (bus.out_pixel !== stall_pix || bus.pix_ready !== 1'b0) stall_bad++;
          bus.out_ready = 1'b0;
          stall_cycles++;
        end
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
          got[out_cnt % 256] = bus.out_pixel;
          out_cnt++;
          last_hs_cyc = cyc;
        end
        prev_valid = bus.out_valid;
      end
    end
  end

  function automatic logic [7:0] pix_val(input int mode, input int idx);
    int r;
    int c;
    r = idx / C;
    c = idx % C;
    if (mode == 0) return 8'(r * 16 + c + 1);
    return (r == 1 && c == 1) ? 8'hFF : 8'h00;
  endfunction

  function automatic logic [7:0] exp_pix(input int idx, input logic [7:0] val);
    int r;
    int c;
    r = idx / C;
    c = idx % C;
    if (r == 0 || r == R - 1 || c == 0 || c == C - 1) return 8'h00;
    return val;
  endfunction

  // Presents pixels in raster order; start is raised while pixel start_at is offered.
  task automatic send_frame(input int mode, input int npix, input int start_at);
    int idx;
    int guard;
    logic hs;
    idx = 0;
    guard = 0;
    while (idx < npix && guard < 2000) begin
      bus.pix_in    = pix_val(mode, idx);
      bus.pix_valid = 1'b1;
      start         = (idx == start_at) ? 1'b1 : 1'b0;
      hs            = (bus.pix_ready === 1'b1);
      @(negedge clk);
      if (hs) idx++;
      guard++;
    end
    bus.pix_valid = 1'b0;
    start         = 1'b0;
  endtask

  task automatic wait_done(input int fd_base);
    int g;
    g = 0;
    while (fd_cnt == fd_base && g < 1000) begin
      @(negedge clk);
      g++;
    end
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  int ob, sb, fb, cb;

  initial begin
    bus.pix_in    = 8'h00;
    bus.pix_valid = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values
    chk("rst_pix_ready", bus.pix_ready, 0);
    chk("rst_sob_start", bus.sob_start, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_pixel", bus.out_pixel, 0);
    chk("rst_win_pixels", bus.win_pixels, 0);
    chk("rst_win_row", bus.win_row, 0);
    chk("rst_win_col", bus.win_col, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_pix_ready", bus.pix_ready, 0);

    // Frame A: ramp image, engine latency 3, start re-pulsed mid-frame
    eng_lat = 3; eng_val = 8'hA5; cap_row = 2; cap_col = 2;
    ob = out_cnt; sb = sob_starts; fb = fd_cnt; cb = cap_hits;
    pulse_start();
    chk("start_busy", busy, 1);
    chk("start_pix_ready", bus.pix_ready, 1);
    send_frame(0, N, 15);
    wait_done(fb);
    chk("A_out_count", out_cnt - ob, N);
    for (int i = 0; i < N; i++) chk("A_pixel", got[(ob + i) % 256], exp_pix(i, 8'hA5));
    chk("A_sob_starts", sob_starts - sb, NInt);
    chk("A_win_hit", cap_hits - cb, 1);
    chk("A_win_2_2", cap_win, 64'h1213142224323334);
    chk("A_frame_done_cnt", fd_cnt - fb, 1);
    chk("A_frame_done_lag", fd_cyc - last_hs_cyc, 1);
    chk("A_busy_after", busy, 0);
    chk("A_sob_latency", lat_bad, 0);
    chk("A_wait_pix_ready", wait_viol, 0);

    // Frame B: single bright pixel, engine returns 255, sink stalls 20 cycles
    eng_lat = 2; eng_val = 8'hFF; cap_row = 1; cap_col = 2;
    ob = out_cnt; sb = sob_starts; fb = fd_cnt; cb = cap_hits;
    stall_len = 20; stall_idx = ob + 8;
    pulse_start();
    send_frame(1, N, -1);
    wait_done(fb);
    chk("B_out_count", out_cnt - ob, N);
    for (int i = 0; i < N; i++) chk("B_pixel", got[(ob + i) % 256], exp_pix(i, 8'hFF));
    chk("B_sob_starts", sob_starts - sb, NInt);
    chk("B_win_hit", cap_hits - cb, 1);
    chk("B_win_1_2", cap_win, 64'h000000FF00000000);
    chk("B_stall_cycles", stall_cycles, 20);
    chk("B_stall_stable", stall_bad, 0);
    chk("B_stalled_pixel", stall_pix, 8'hFF);
    chk("B_frame_done_cnt", fd_cnt - fb, 1);
    chk("B_sob_latency", lat_bad, 0);
    chk("B_wait_pix_ready", wait_viol, 0);
`ifdef SOBEL_SCAN_STATS_EN
    chk("B_edge_count", edge_count, NInt);
`endif

    // Frame C: abort by reset after 10 pixels, then a clean frame
    eng_lat = 1; eng_val = 8'h3C;
    pulse_start();
    send_frame(0, 10, -1);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("C_rst_busy", busy, 0);
    chk("C_rst_pix_ready", bus.pix_ready, 0);
    chk("C_rst_out_valid", bus.out_valid, 0);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    cap_row = 3; cap_col = 4;
    ob = out_cnt; sb = sob_starts; fb = fd_cnt; cb = cap_hits;
    pulse_start();
    send_frame(0, N, -1);
    wait_done(fb);
    chk("C_out_count", out_cnt - ob, N);
    for (int i = 0; i < N; i++) chk("C_pixel", got[(ob + i) % 256], exp_pix(i, 8'h3C));
    chk("C_sob_starts", sob_starts - sb, NInt);
    chk("C_win_hit", cap_hits - cb, 1);
    chk("C_win_3_4", cap_win, 64'h2425263436444546);
    chk("C_frame_done_cnt", fd_cnt - fb, 1);
    chk("C_sob_latency", lat_bad, 0);
    chk("C_wait_pix_ready", wait_viol, 0);
`ifdef SOBEL_SCAN_STATS_EN
    chk("C_edge_count", edge_count, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
